// File: rtl/ram_pipe_if.sv
// Request/response bus between a data-bus master and the ram_pipe slave.
// Signal names are from the slave's point of view.
interface ram_pipe_if #(
    parameter int unsigned DW = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [31:0]       addr_i;
    logic [DW-1:0]     data_i;
    logic [DW/8-1:0]   sel_i;
    logic              we_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DW-1:0]     data_o;
    logic              err_o;

    modport slave (
        input  req_valid_i, addr_i, data_i, sel_i, we_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, data_o, err_o
    );

    modport master (
        output req_valid_i, addr_i, data_i, sel_i, we_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, data_o, err_o
    );
endinterface

// File: rtl/ram_pipe.sv
// Pipelined single-port RAM slave: byte-lane writes, in-order responses,
// credit-limited outstanding requests and an error flag for bad addresses.
module ram_pipe #(
    parameter int unsigned DP        = 4096,
    parameter int unsigned DW        = 32,
    parameter logic [31:0] BASE      = 32'h1000_0000,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned RSP_DEPTH = 2,
    parameter bit          CUT_READY = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    ram_pipe_if.slave bus
);

    localparam int unsigned NB   = DW / 8;
    localparam int unsigned OB   = $clog2(NB);
    localparam int unsigned AW   = $clog2(DP);
    localparam int unsigned PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned FN   = 1 << PW;
    localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);
    localparam logic [32:0] SPAN = 33'(DP) * 33'(NB);

    // Request decode
    logic [31:0]   off_c;
    logic [AW-1:0] idx_c;
    logic          err_c;
    logic          req_ready_c;
    logic          acc_c;
    logic          wr_en_c;
    logic          rd_en_c;

    assign off_c   = bus.addr_i - BASE;
    assign idx_c   = off_c[OB +: AW];
    assign err_c   = ({1'b0, off_c} >= SPAN) || (bus.addr_i[OB-1:0] != '0);
    assign acc_c   = bus.req_valid_i && req_ready_c && !rst;
    assign wr_en_c = acc_c && bus.we_i && !err_c;
    assign rd_en_c = acc_c && !bus.we_i && !err_c;

    // Storage array; writes land at acceptance so a following read sees them
    logic [DW-1:0] mem_q [DP];
    logic [DW-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int k = 0; k < int'(NB); k++) begin
                if (bus.sel_i[k]) begin
                    mem_q[idx_c][8*k +: 8] <= bus.data_i[8*k +: 8];
                end
            end
        end
        if (rd_en_c) begin
            rd_q <= mem_q[idx_c];
        end
    end

    // Stage 1: array output alongside the captured request attributes
    logic          s1_vld_q;
    logic          s1_err_q;
    logic          s1_we_q;
    logic [DW-1:0] s1_data_c;
    logic          s1_err_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_err_q <= 1'b0;
            s1_we_q  <= 1'b0;
        end else begin
            s1_vld_q <= acc_c;
            if (acc_c) begin
                s1_err_q <= err_c;
                s1_we_q  <= bus.we_i;
            end
        end
    end

    assign s1_data_c = (s1_vld_q && !s1_err_q && !s1_we_q) ? rd_q : '0;
    assign s1_err_c  = s1_vld_q && s1_err_q;

    logic          last_vld_c;
    logic          last_err_c;
    logic [DW-1:0] last_data_c;

    generate
        if (READ_LAT >= 2) begin : g_lat2
            logic          s2_vld_q;
            logic          s2_err_q;
            logic [DW-1:0] s2_data_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_vld_q  <= 1'b0;
                    s2_err_q  <= 1'b0;
                    s2_data_q <= '0;
                end else begin
                    s2_vld_q  <= s1_vld_q;
                    s2_err_q  <= s1_err_c;
                    s2_data_q <= s1_data_c;
                end
            end

            assign last_vld_c  = s2_vld_q;
            assign last_err_c  = s2_err_q;
            assign last_data_c = s2_data_q;
        end else begin : g_lat1
            assign last_vld_c  = s1_vld_q;
            assign last_err_c  = s1_err_c;
            assign last_data_c = s1_data_c;
        end
    endgenerate

    // Response FIFO; the last pipeline stage bypasses it when it is empty
    logic [DW-1:0] fifo_data_q [FN];
    logic [FN-1:0] fifo_err_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          fifo_empty_c;
    logic          push_c;
    logic          pop_c;
    logic          rsp_valid_c;
    logic          rsp_hs_c;

    assign fifo_empty_c = (fifo_cnt_q == '0);
    assign rsp_valid_c  = !fifo_empty_c || last_vld_c;
    assign rsp_hs_c     = rsp_valid_c && bus.rsp_ready_i;
    assign push_c       = last_vld_c && !(fifo_empty_c && bus.rsp_ready_i);
    assign pop_c        = !fifo_empty_c && bus.rsp_ready_i;
    assign req_ready_c  = (out_cnt_q < CW'(RSP_DEPTH)) || (!CUT_READY && rsp_hs_c);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        out_cnt_d  = out_cnt_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        case ({acc_c, rsp_hs_c})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_data_q[wr_ptr_q] <= last_data_c;
            fifo_err_q[wr_ptr_q]  <= last_err_c;
        end
    end

    assign bus.req_ready_o = req_ready_c;
    assign bus.rsp_valid_o = rsp_valid_c;
    assign bus.data_o      = fifo_empty_c ? last_data_c : fifo_data_q[rd_ptr_q];
    assign bus.err_o       = fifo_empty_c ? last_err_c  : fifo_err_q[rd_ptr_q];

    // Credits must keep the FIFO and the outstanding count in range
    a_fifo_no_ovf: assert property (@(posedge clk) disable iff (rst)
        !(push_c && !pop_c && (fifo_cnt_q >= CW'(RSP_DEPTH))));
    a_cnt_no_ovf: assert property (@(posedge clk) disable iff (rst)
        !(acc_c && !rsp_hs_c && (out_cnt_q >= CW'(RSP_DEPTH))));

endmodule

// File: doc/ram_pipe.md
# ram_pipe

Parametrised, pipelined on-chip RAM slave for the core's data bus. It stores `DP` words of `DW` bits with byte-lane write enables. Requests and responses use separate valid/ready channels, with up to `RSP_DEPTH` outstanding requests, one response per request (reads and writes alike) and an error flag for out-of-range or misaligned accesses. It is the drop-in replacement for the fixed 32-bit, single-outstanding RAM peripheral on the bus matrix.

## Interface
Parameters:
- `DP`, 4096: depth in words; power of two, ≥ 16.
- `DW`, 32: data width; 32 or 64.
- `BASE`, 32'h1000_0000: byte base address; aligned to `DP*DW/8`.
- `READ_LAT`, 1: array-to-response latency; 1 (array output) or 2 (extra output register).
- `RSP_DEPTH`, 2: response buffer entries, equal to the outstanding-request credits; ≥ `READ_LAT`.
- `CUT_READY`, 0: 1 means `req_ready_o` is registered only, with no combinational path from `rsp_ready_i`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: request accepted when high together with `req_valid_i`.
- `addr_i`, in, 32: byte address.
- `data_i`, in, `DW`: write data.
- `sel_i`, in, `DW/8`: byte enables; bit k enables bits [8k+7:8k].
- `we_i`, in, 1: 1 means write, 0 means read.
- `rsp_valid_o`, out, 1: response valid.
- `rsp_ready_i`, in, 1: response consumed when high together with `rsp_valid_o`.
- `data_o`, out, `DW`: read data; 0 for writes and errors.
- `err_o`, out, 1: response error flag, qualified by `rsp_valid_o`.

## Operation
- Definitions: `OB = log2(DW/8)`, `off = addr_i - BASE` (32-bit wrap), `idx = off[OB+log2(DP)-1:OB]`.
- Error conditions: the request errors if `off >= DP*DW/8` or `addr_i[OB-1:0] != 0`.
  - An erroring request still produces exactly one response, with `err_o=1` and `data_o=0`.
  - A write with error leaves the array unchanged.
- Write: on acceptance, update `mem[idx]` byte-wise per `sel_i`. `sel_i=0` is a legal no-op write that still responds. Response: `err_o=0`, `data_o=0`.
- Read: on acceptance, read `mem[idx]`. `sel_i` is ignored and the full word is returned.
- Ordering:
  - Responses return strictly in request order.
  - A read accepted in the cycle after a write to the same `idx` returns the new data. No bypass is needed because there is a single port and the write updates the array at acceptance.
- Credit counter `out_cnt`, range 0..`RSP_DEPTH`: counts requests accepted whose response has not yet been consumed.
  - +1 on request handshake, −1 on response handshake; both in the same cycle leaves it unchanged.
  - CUT_READY=0: `req_ready_o = (out_cnt < RSP_DEPTH) | (rsp_valid_o & rsp_ready_i)`.
  - CUT_READY=1: `req_ready_o = (out_cnt < RSP_DEPTH)`, using registered state only.
- Pipeline: the request stage captures `err` and `we`, followed by `READ_LAT` stages feeding a `RSP_DEPTH`-entry FIFO whose head drives the response outputs.
  - Credits guarantee the FIFO never overflows. Data in flight must never be dropped or stalled in the array stage.
- Memory contents are not reset or initialised; a read of an unwritten word returns X in simulation.

## Timing
- Reset, sampled on an edge while `rst`=1: `rsp_valid_o=0`, `data_o=0`, `err_o=0`, `out_cnt=0`, FIFO empty.
  - `req_ready_o` is 1 from the first cycle after reset.
  - All in-flight requests are discarded; writes already performed are kept.
- Latency: a request accepted at edge E presents its response from edge E+`READ_LAT`, provided the FIFO ahead of it is empty. It holds until consumed.
- Throughput: 1 request per cycle sustained while `rsp_ready_i=1`.
  - CUT_READY=0 needs `RSP_DEPTH ≥ READ_LAT`.
  - CUT_READY=1 needs `RSP_DEPTH ≥ READ_LAT+1`.
- Handshake stability:
  - While `rsp_valid_o=1` and `rsp_ready_i=0`, `data_o` and `err_o` stay stable.
  - `rsp_valid_o` never drops without a handshake, except on reset.
- Full: with `out_cnt=RSP_DEPTH` and no response handshake, `req_ready_o=0`. The requester may hold `req_valid_i` and its payload; no request is lost.
- Empty: with `out_cnt=0`, `rsp_valid_o=0`.

## Test plan
- Defaults: write 32'hDEADBEEF to `BASE+0x10` with `sel_i=4'hF`, then read `BASE+0x10` -> response 1 has `err_o=0`, `data_o=0`; response 2 has `data_o=32'hDEADBEEF` and arrives 1 cycle after acceptance.
- Byte lanes: write 32'h11223344 (sel F), then 32'hAABBCCDD (sel 4'b0101), then read -> 32'h11BB33DD.
- Errors:
  - Read `BASE+DP*4` -> `err_o=1`, `data_o=0`.
  - Write `BASE+0x2`, then read `BASE+0x0` -> first response has `err_o=1`; the read returns the prior content unchanged.
- Back-pressure, `RSP_DEPTH=2`, `rsp_ready_i=0`, 4 back-to-back reads -> exactly 2 accepted and `req_ready_o=0`. Then raise `rsp_ready_i` -> all 4 responses arrive in order with correct data and none are dropped.
- Streaming: 64 back-to-back mixed requests with `rsp_ready_i=1`, run for `READ_LAT` ∈ {1,2} × `CUT_READY` ∈ {0,1} with minimum legal depth -> one request per cycle and responses matching the scoreboard.
- Reset mid-operation: assert `rst` with 2 outstanding -> next cycle `rsp_valid_o=0`, `req_ready_o=1`, no stale response afterwards; prior completed writes are still readable.
